// File: rtl/lane_scanner_pkg.sv
// Shared types and helpers for lane_scanner: FSM state encoding, mode constants
// and the lane-index width function.
package lane_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_AUTO   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Index width is max(1, clog2(lanes)) so a 2-lane scanner still gets one bit.
    function automatic int idx_width(input int lanes);
        return (lanes > 2) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/lane_scanner_dwell_counter.sv
// Dwell timer: counts enabled cycles since the last clear and pulses tick on the
// DWELL-th one, clearing itself on that same edge.
module dwell_counter #(
    parameter int DWELL = 50000,
    localparam int CW = $clog2(DWELL + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [CW-1:0] r_count;

    assign tick = en && !clr && (r_count == CW'(DWELL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= tick ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/lane_scanner.sv
// Registered lane selector: presents one WIDTH-bit field of a packed bus, chosen
// manually by sel or by an automatic dwell-timed scan.
// Optional feature macro: LANE_SCANNER_SNAPSHOT_EN (coherent per-sweep sample in auto mode).
module lane_scanner
    import lane_scanner_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 10,
    parameter int DWELL = 50000,
    localparam int IW = idx_width(LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*WIDTH-1:0] data_in,
    input  logic                   mode,
    input  logic [IW-1:0]          sel,
    output logic [WIDTH-1:0]       lane_out,
    output logic [IW-1:0]          lane_idx,
    output logic                   lane_valid,
    output logic                   sweep_done
);

    localparam logic [IW-1:0] TOP_IDX = IW'(LANES - 1);

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_lane_out;
    logic [IW-1:0]    r_lane_idx;
    logic             r_lane_valid;
    logic             r_sweep_done;

    logic             w_cnt_en;
    logic             w_tick;
    logic [IW-1:0]    w_idx_next;
    logic             w_sweep_next;
    logic             w_capture;
    logic [LANES*WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_fields [LANES];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   w_state_next = (mode == MODE_AUTO) ? ST_AUTO : ST_MANUAL;
            ST_MANUAL: if (mode == MODE_AUTO)   w_state_next = ST_AUTO;
            ST_AUTO:   if (mode == MODE_MANUAL) w_state_next = ST_MANUAL;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // The counter only runs while staying in AUTO; entry and exit both clear it.
    assign w_cnt_en = (r_state == ST_AUTO) && (w_state_next == ST_AUTO);

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (!w_cnt_en),
        .en   (w_cnt_en),
        .tick (w_tick)
    );

    always_comb begin
        w_idx_next   = r_lane_idx;
        w_sweep_next = 1'b0;
        w_capture    = 1'b0;
        case (w_state_next)
            ST_MANUAL: begin
                w_idx_next = (sel > TOP_IDX) ? TOP_IDX : sel;
            end
            ST_AUTO: begin
                if (!w_cnt_en) begin
                    w_idx_next = '0;
                    w_capture  = 1'b1;
                end else if (w_tick) begin
                    if (r_lane_idx == TOP_IDX) begin
                        w_idx_next   = '0;
                        w_sweep_next = 1'b1;
                        w_capture    = 1'b1;
                    end else begin
                        w_idx_next = r_lane_idx + IW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef LANE_SCANNER_SNAPSHOT_EN
    logic [LANES*WIDTH-1:0] r_snap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap <= '0;
        end else if (w_capture) begin
            r_snap <= data_in;
        end
    end

    // On a capture edge the fresh sample is data_in itself, so read it directly.
    assign w_src = (w_state_next == ST_AUTO && !w_capture) ? r_snap : data_in;
`else
    assign w_src = data_in;
`endif

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_field
            assign w_fields[gi] = w_src[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_lane_out   <= '0;
            r_lane_idx   <= '0;
            r_lane_valid <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_lane_out   <= w_fields[w_idx_next];
            r_lane_idx   <= w_idx_next;
            // Keyed on the current state so the IDLE cycle after reset reads invalid.
            r_lane_valid <= (r_state != ST_IDLE);
            r_sweep_done <= w_sweep_next;
        end
    end

    assign lane_out   = r_lane_out;
    assign lane_idx   = r_lane_idx;
    assign lane_valid = r_lane_valid;
    assign sweep_done = r_sweep_done;

endmodule

// File: doc/lane_scanner.md
# lane_scanner

- Parametrised, registered successor to the board's fixed 4×10-bit field selector.
- Takes a packed bus of LANES fields, each WIDTH bits wide, and presents one field at a time on a registered output.
- Field selection is either manual, by a select input, or automatic, stepping through the lanes with a programmable dwell time.
- Sits between the value-formatting logic and multiplexed display or serial drivers on the EP4CE6 board.

## Interface

Parameters:

- LANES, default 4: number of fields; minimum 2; need not be a power of two.
- WIDTH, default 10: bits per field.
- DWELL, default 50000: clock cycles each lane is held in auto mode; minimum 1.

Ports:

- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  LANES*WIDTH  packed fields; lane k = data_in[k*WIDTH +: WIDTH].
- mode  in  1  0 = manual, 1 = auto-scan.
- sel  in  IW = max(1, clog2(LANES))  manual lane select.
- lane_out  out  WIDTH  currently presented field.
- lane_idx  out  IW  index of the lane on lane_out.
- lane_valid  out  1  lane_out/lane_idx are meaningful.
- sweep_done  out  1  one-cycle pulse when auto scan wraps.

## Operation

- FSM states: IDLE, MANUAL, AUTO.
  - Reset enters IDLE.
  - IDLE → MANUAL (mode=0) or AUTO (mode=1) on the first clock after reset release.
  - MANUAL ↔ AUTO whenever mode differs from the current state.
- Reset values (asynchronous): lane_out=0, lane_idx=0, lane_valid=0, sweep_done=0, dwell counter=0, state=IDLE.
- IDLE: lane_valid=0.
- MANUAL and AUTO: lane_valid=1.
- MANUAL behaviour:
  - lane_idx ← min(sel, LANES-1); out-of-range sel clamps to the top lane.
  - lane_out ← field[lane_idx_next], re-sampled every cycle, so live data changes propagate.
- AUTO entry (from IDLE or MANUAL):
  - lane_idx ← 0.
  - dwell counter ← 0.
- AUTO steady state:
  - The dwell counter increments each cycle.
  - When the counter equals DWELL-1, it clears and lane_idx advances.
  - Wrap: lane_idx goes LANES-1 → 0. On that same edge sweep_done=1 for exactly one cycle.
- Leaving AUTO: the counter clears and sweep_done is never asserted on the switching edge.
- Arithmetic:
  - The dwell counter is clog2(DWELL+1) bits wide and unsigned.
  - Index arithmetic is modulo LANES, with an explicit compare, not a power-of-two wrap.

## Timing

- Latency: sel or data_in change → lane_out updated on the next rising edge (1 cycle). No combinational path from any input to any output.
- Auto cadence: each lane is visible for exactly DWELL cycles; a full sweep is LANES*DWELL cycles.
- DWELL=1: lane_idx advances every cycle, and sweep_done pulses every LANES cycles.
- Mode change takes effect on the next edge. A toggle mid-dwell restarts from lane 0 with a full dwell.
- Reset asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock edge. After release, one IDLE cycle precedes lane_valid=1.

## Configuration

- Macro: LANE_SCANNER_SNAPSHOT_EN.
- Defined:
  - A LANES*WIDTH snapshot register captures data_in on AUTO entry and on every wrap edge.
  - In AUTO, lane_out is taken from the snapshot, so every lane of one sweep comes from one coherent sample.
  - MANUAL still uses live data_in.
  - The snapshot resets to 0.
- Undefined: there is no snapshot register, and AUTO reads live data_in exactly as MANUAL does.

## Structure

- Package lane_scanner_pkg holds:
  - the state enum (IDLE, MANUAL, AUTO);
  - the MODE_MANUAL/MODE_AUTO constants;
  - a clog2-based index-width helper function.
- Sub-module dwell_counter:
  - parameter DWELL;
  - ports clk, rst, clr, en, tick;
  - tick is a one-cycle pulse on the DWELL-th enabled cycle after clr.
- The top level holds the FSM, index logic, field extraction and the optional snapshot register.

## Test plan

- Reset check: assert rst mid-run → lane_out=0, lane_idx=0, lane_valid=0, sweep_done=0 before the next edge. After release, lane_valid=1 on the second edge.
- Manual select: LANES=4, WIDTH=10, data_in={10'h3FF,10'h155,10'h0AA,10'h001}, sel=2 → one cycle later lane_out=10'h155, lane_idx=2. Then sel=0 → lane_out=10'h001.
- Clamp: LANES=3, sel=3 → lane_idx=2, lane_out=field 2.
- Auto cadence: LANES=3, DWELL=3 → lane_idx sequence 0,0,0,1,1,1,2,2,2,0. sweep_done high only on the cycle lane_idx returns to 0.
- Snapshot: auto mode, change lane 2 from 10'h0AA to 10'h111 while lane_idx=0.
  - With LANE_SCANNER_SNAPSHOT_EN: lane 2 shows 10'h0AA this sweep and 10'h111 next sweep.
  - Without it: lane 2 shows 10'h111 this sweep.
- Mode toggle mid-dwell: auto at lane 1, counter 1 → set mode=0, sel=3 → next edge lane_idx=3, no sweep_done. Set mode=1 → lane_idx=0, with a full DWELL hold.
